// File: rtl/btn_event_decoder_if.sv
// Button-event bundle: debounced level in, event pulses and hold status out.
// The decoder sits on the slave side; the level source and the event consumers sit on the master side.
interface btn_event_decoder_if;
   logic       btn_level;
   logic       press;
   logic       release_evt;
   logic       long_press;
   logic       repeat_evt;
   logic       held;
   logic       long_held;
   logic [7:0] repeat_cnt;

   modport master (
      output btn_level,
      input  press, release_evt, long_press, repeat_evt, held, long_held, repeat_cnt
   );

   modport slave (
      input  btn_level,
      output press, release_evt, long_press, repeat_evt, held, long_held, repeat_cnt
   );
endinterface

// File: rtl/btn_event_decoder.sv
// Decodes a debounced button level into press/release/long-press/auto-repeat pulses,
// hold-status levels and a saturating repeat counter. All event outputs are registered.
module btn_event_decoder #(
   parameter int LONG_PERIOD   = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic                 clk,
   input  logic                 reset,
   btn_event_decoder_if.slave   bus
);

   typedef enum logic [1:0] {DISARMED, IDLE, PRESSED, LONG} state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PERIOD - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
   localparam bit               REP_EN    = (REPEAT_PERIOD != 0);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [7:0]       rcnt, rcnt_nx;
   logic             press_nx, rel_nx, long_nx, rpt_nx;
   logic             press_p1, rel_p1, long_p1, rpt_p1;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Next-state and event decode; release is tested first so it wins over long/repeat.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rcnt_nx  = rcnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      long_nx  = 1'b0;
      rpt_nx   = 1'b0;
      case (state)
         DISARMED: begin
            if (!bus.btn_level) state_nx = IDLE;
         end
         IDLE: begin
            if (bus.btn_level) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
               press_nx = 1'b1;
               rcnt_nx  = 8'd0;
            end
         end
         PRESSED: begin
            if (!bus.btn_level) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rel_nx   = 1'b1;
            end else if (cnt == LONG_LAST) begin
               state_nx = LONG;
               cnt_nx   = '0;
               long_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         LONG: begin
            if (!bus.btn_level) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rel_nx   = 1'b1;
            end else if (REP_EN) begin
               if (cnt == REP_LAST) begin
                  cnt_nx  = '0;
                  rpt_nx  = 1'b1;
                  rcnt_nx = sat_inc(rcnt);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nx = DISARMED;
      endcase
   end

   // Stage p1: registered state, counters and event pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= DISARMED;
         cnt      <= '0;
         rcnt     <= 8'd0;
         press_p1 <= 1'b0;
         rel_p1   <= 1'b0;
         long_p1  <= 1'b0;
         rpt_p1   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         rcnt     <= rcnt_nx;
         press_p1 <= press_nx;
         rel_p1   <= rel_nx;
         long_p1  <= long_nx;
         rpt_p1   <= rpt_nx;
      end
   end

   assign bus.press       = press_p1;
   assign bus.release_evt = rel_p1;
   assign bus.long_press  = long_p1;
   assign bus.repeat_evt  = rpt_p1;
   assign bus.held        = (state == PRESSED) || (state == LONG);
   assign bus.long_held   = (state == LONG);
   assign bus.repeat_cnt  = rcnt;

endmodule
